// File: rtl/delay_diff_lanes.sv
// delay_diff_lanes: LANES-wide intra-word delay differentiator.
// Each accepted word carries LANES time-ordered samples (lane LANES-1 newest).
// Per lane the result is the sample D positions earlier in the stream minus
// the current sample (or the reverse / the delayed sample alone, per mode).
// Pipeline: S1 input + history, S2 index + mux, S3 arithmetic + output.
// Optional build macro: DELAY_DIFF_SAT_EN selects a saturating difference;
// without it the difference wraps to DATA_WIDTH bits.
`timescale 1ns/1ps
module delay_diff_lanes #(
    parameter int LANES      = 16,
    parameter int DATA_WIDTH = 20,
    parameter int MAX_DELAY  = 64,
    parameter int DELAY_W    = 7
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [DELAY_W-1:0]            delay_sel,
    input  logic [1:0]                    mode,
    input  logic                          valid_in,
    input  logic [LANES*DATA_WIDTH-1:0]   data_in,
    output logic [LANES*DATA_WIDTH-1:0]   diff_out,
    output logic [LANES*DATA_WIDTH-1:0]   data_cur_out,
    output logic                          valid_out,
    output logic                          delay_clamped
);

    // Number of history words needed so that lane 0 can reach MAX_DELAY back.
    localparam int NCOL  = (LANES - 1 + MAX_DELAY) / LANES + 1;
    // History flattened by age: index 0 is the newest sample.
    localparam int NSAMP = NCOL * LANES;
    localparam int OFF_W = $clog2(NSAMP);
    localparam int CNT_W = $clog2(NCOL);
    localparam int LW    = LANES * DATA_WIDTH;

`ifdef DELAY_DIFF_SAT_EN
    // One guard bit lets overflow be detected and saturated.
    localparam int SUB_W = DATA_WIDTH + 1;
`else
    // Wrapping keeps only the low DATA_WIDTH bits, so the guard bit is dropped.
    localparam int SUB_W = DATA_WIDTH;
`endif

    genvar gi, gj;

    // ------------------------------------------------------------------
    // Input-side decode: effective delay, clamp flag, warm qualifier
    // ------------------------------------------------------------------
    logic [DELAY_W-1:0] d_eff;
    logic               clamp_now;
    logic [CNT_W-1:0]   cnt_reg;
    logic [CNT_W-1:0]   cnt_prior;
    logic [CNT_W-1:0]   cnt_inc;
    logic [OFF_W-1:0]   thr_sum;
    logic [OFF_W-1:0]   thr;
    logic               warm_now;

    // Map delay_sel onto the legal range 1..MAX_DELAY and flag any clamping.
    always_comb begin
        d_eff     = delay_sel;
        clamp_now = 1'b0;
        if (delay_sel == '0) begin
            d_eff     = DELAY_W'(1);
            clamp_now = 1'b1;
        end else if (delay_sel > DELAY_W'(MAX_DELAY)) begin
            d_eff     = DELAY_W'(MAX_DELAY);
            clamp_now = 1'b1;
        end
    end

    // A flush in the same cycle makes this beat the first one after a clear.
    assign cnt_prior = flush ? '0 : cnt_reg;
    assign cnt_inc   = (cnt_prior == CNT_W'(NCOL - 1)) ? cnt_prior : cnt_prior + CNT_W'(1);

    // Oldest column touched at this delay; the beat is warm once that many
    // real words precede it.
    assign thr_sum  = OFF_W'(LANES - 1) + OFF_W'(d_eff);
    assign thr      = thr_sum / OFF_W'(LANES);
    assign warm_now = (OFF_W'(cnt_prior) >= thr);

    // ------------------------------------------------------------------
    // S1: history shift register and per-beat control capture
    // ------------------------------------------------------------------
    logic [LW-1:0]      hist_reg [NCOL];
    logic               valid1_reg;
    logic               warm1_reg;
    logic               clamp1_reg;
    logic [DELAY_W-1:0] d1_reg;
    logic [1:0]         mode1_reg;

    // History advances only on accepted words; flush zeroes older columns.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NCOL; c++) begin
                hist_reg[c] <= '0;
            end
        end else if (valid_in) begin
            hist_reg[0] <= data_in;
            for (int c = 1; c < NCOL; c++) begin
                hist_reg[c] <= flush ? '0 : hist_reg[c-1];
            end
        end else if (flush) begin
            for (int c = 0; c < NCOL; c++) begin
                hist_reg[c] <= '0;
            end
        end
    end

    // Capture delay, mode, warm state and clamp flag alongside each beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg    <= '0;
            valid1_reg <= 1'b0;
            warm1_reg  <= 1'b0;
            clamp1_reg <= 1'b0;
            d1_reg     <= '0;
            mode1_reg  <= '0;
        end else begin
            valid1_reg <= valid_in;
            if (valid_in) begin
                cnt_reg    <= cnt_inc;
                warm1_reg  <= warm_now;
                clamp1_reg <= clamp_now;
                d1_reg     <= d_eff;
                mode1_reg  <= mode;
            end else if (flush) begin
                cnt_reg <= '0;
            end
        end
    end

    // Re-index history by sample age so each lane's tap is a single lookup.
    logic [DATA_WIDTH-1:0] age_samples [NSAMP];

    for (gj = 0; gj < NCOL; gj++) begin : g_age_col
        for (gi = 0; gi < LANES; gi++) begin : g_age_lane
            assign age_samples[gj*LANES + (LANES - 1 - gi)] =
                hist_reg[gj][gi*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // ------------------------------------------------------------------
    // S2: per-lane delayed-sample mux
    // ------------------------------------------------------------------
    logic       valid2_reg;
    logic       warm2_reg;
    logic       clamp2_reg;
    logic [1:0] mode2_reg;

    // Control travels with the beat into the mux stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid2_reg <= 1'b0;
            warm2_reg  <= 1'b0;
            clamp2_reg <= 1'b0;
            mode2_reg  <= '0;
        end else begin
            valid2_reg <= valid1_reg;
            if (valid1_reg) begin
                warm2_reg  <= warm1_reg;
                clamp2_reg <= clamp1_reg;
                mode2_reg  <= mode1_reg;
            end
        end
    end

    logic [LW-1:0] res_vec;
    logic [LW-1:0] cur_vec;

    for (gi = 0; gi < LANES; gi++) begin : g_lane
        logic [OFF_W-1:0]      off;
        logic [DATA_WIDTH-1:0] dly2_reg;
        logic [DATA_WIDTH-1:0] cur2_reg;
        logic [SUB_W-1:0]      ext_dly;
        logic [SUB_W-1:0]      ext_cur;
        logic [SUB_W-1:0]      sub;
        logic [DATA_WIDTH-1:0] res;

        // Age of the delayed sample: distance of this lane from the newest
        // sample plus the effective delay.
        assign off = OFF_W'(LANES - 1 - gi) + OFF_W'(d1_reg);

        // Register the delayed tap and the current sample for this lane.
        always_ff @(posedge clk) begin
            if (rst) begin
                dly2_reg <= '0;
                cur2_reg <= '0;
            end else if (valid1_reg) begin
                dly2_reg <= age_samples[off];
                cur2_reg <= hist_reg[0][gi*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        // Signed difference in the selected direction, then saturate or wrap.
        always_comb begin
`ifdef DELAY_DIFF_SAT_EN
            ext_dly = {dly2_reg[DATA_WIDTH-1], dly2_reg};
            ext_cur = {cur2_reg[DATA_WIDTH-1], cur2_reg};
`else
            ext_dly = dly2_reg;
            ext_cur = cur2_reg;
`endif
            if (mode2_reg == 2'b01) begin
                sub = ext_cur - ext_dly;
            end else begin
                sub = ext_dly - ext_cur;
            end
            res = sub[DATA_WIDTH-1:0];
`ifdef DELAY_DIFF_SAT_EN
            if (sub[DATA_WIDTH] != sub[DATA_WIDTH-1]) begin
                res = sub[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                      : {1'b0, {(DATA_WIDTH-1){1'b1}}};
            end
`endif
            if (mode2_reg == 2'b10) begin
                res = dly2_reg;
            end
        end

        assign res_vec[gi*DATA_WIDTH +: DATA_WIDTH] = res;
        assign cur_vec[gi*DATA_WIDTH +: DATA_WIDTH] = cur2_reg;
    end

    // ------------------------------------------------------------------
    // S3: output registers
    // ------------------------------------------------------------------
    logic [LW-1:0] diff_out_reg;
    logic [LW-1:0] data_cur_out_reg;
    logic          valid_out_reg;
    logic          delay_clamped_reg;

    // Data outputs load only on a beat; valid_out drops on bubbles and cold beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            diff_out_reg      <= '0;
            data_cur_out_reg  <= '0;
            valid_out_reg     <= 1'b0;
            delay_clamped_reg <= 1'b0;
        end else begin
            valid_out_reg <= valid2_reg & warm2_reg;
            if (valid2_reg) begin
                diff_out_reg      <= res_vec;
                data_cur_out_reg  <= cur_vec;
                delay_clamped_reg <= clamp2_reg;
            end
        end
    end

    assign diff_out      = diff_out_reg;
    assign data_cur_out  = data_cur_out_reg;
    assign valid_out     = valid_out_reg;
    assign delay_clamped = delay_clamped_reg;

endmodule

// File: tb/tb_delay_diff_lanes.sv
// tb_delay_diff_lanes: directed stimulus with a stream-model scoreboard.
// Expected results are computed from a record of every accepted sample
// since the last reset/flush and pushed when a warm beat is driven.
`timescale 1ns/1ps
module tb_delay_diff_lanes;

    localparam int LANES   = 16;
    localparam int DW      = 20;
    localparam int MAXD    = 64;
    localparam int DELAY_W = 7;
    localparam int LW      = LANES * DW;

`ifdef DELAY_DIFF_SAT_EN
    localparam logic [DW-1:0] SAT_EXP = 20'h7FFFF;
`else
    localparam logic [DW-1:0] SAT_EXP = 20'hFFFFF;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               flush;
    logic [DELAY_W-1:0] delay_sel;
    logic [1:0]         mode;
    logic               valid_in;
    logic [LW-1:0]      data_in;
    logic [LW-1:0]      diff_out;
    logic [LW-1:0]      data_cur_out;
    logic               valid_out;
    logic               delay_clamped;

    always #5 clk = ~clk;

    delay_diff_lanes #(
        .LANES      (LANES),
        .DATA_WIDTH (DW),
        .MAX_DELAY  (MAXD),
        .DELAY_W    (DELAY_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .delay_sel     (delay_sel),
        .mode          (mode),
        .valid_in      (valid_in),
        .data_in       (data_in),
        .diff_out      (diff_out),
        .data_cur_out  (data_cur_out),
        .valid_out     (valid_out),
        .delay_clamped (delay_clamped)
    );

    typedef struct packed {
        logic [LW-1:0] diff;
        logic [LW-1:0] cur;
        logic          clamp;
    } exp_t;

    exp_t          exp_q[$];
    int            stream[$];
    int            beats_since = 0;
    int            ramp_n      = 0;
    int            checks      = 0;
    int            errors      = 0;
    int            beat_no     = 0;
    logic          hold_en     = 1'b0;
    logic [LW-1:0] last_diff   = '0;

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    function automatic int sext(input logic [DW-1:0] v);
        return int'($signed(v));
    endfunction

    // Drive one cycle; if valid, extend the stream model and queue the expectation.
    task automatic drive(input logic v, input logic [DELAY_W-1:0] dsel, input logic [1:0] md,
                         input logic fl, input logic [LW-1:0] word);
        int            d;
        int            base;
        int            p;
        int            cur_s;
        int            dly_s;
        int            res;
        logic [DW-1:0] r;
        exp_t          e;
        valid_in  = v;
        delay_sel = dsel;
        mode      = md;
        flush     = fl;
        data_in   = word;
        if (fl) begin
            stream.delete();
            beats_since = 0;
        end
        if (v) begin
            d = (dsel == 0) ? 1 : ((dsel > MAXD) ? MAXD : int'(dsel));
            e.clamp = (dsel == 0) || (dsel > MAXD);
            base = stream.size();
            for (int k = 0; k < LANES; k++) stream.push_back(sext(word[k*DW +: DW]));
            for (int k = 0; k < LANES; k++) begin
                cur_s = stream[base + k];
                p     = base + k - d;
                dly_s = (p >= 0) ? stream[p] : 0;
                if (md == 2'b01)      res = cur_s - dly_s;
                else if (md == 2'b10) res = dly_s;
                else                  res = dly_s - cur_s;
`ifdef DELAY_DIFF_SAT_EN
                if (md != 2'b10) begin
                    if (res > 524287)  res = 524287;
                    if (res < -524288) res = -524288;
                end
`endif
                r = res[DW-1:0];
                e.diff[k*DW +: DW] = r;
                e.cur[k*DW +: DW]  = word[k*DW +: DW];
            end
            if (beats_since * LANES >= d) exp_q.push_back(e);
            beats_since++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic ramp(input logic v, input logic [DELAY_W-1:0] dsel, input logic [1:0] md, input logic fl);
        logic [LW-1:0] w;
        for (int k = 0; k < LANES; k++) w[k*DW +: DW] = v ? DW'(LANES * ramp_n + k) : DW'($urandom);
        if (v) ramp_n++;
        drive(v, dsel, md, fl, w);
    endtask

    // Scoreboard: every valid output beat must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (valid_out) begin
            check("sb_nonempty", LW'(exp_q.size() != 0), LW'(1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                beat_no++;
                check("diff_out", diff_out, e.diff);
                check("data_cur_out", data_cur_out, e.cur);
                check("delay_clamped", LW'(delay_clamped), LW'(e.clamp));
                $display("beat %0d: diff0=%h cur0=%h clamp=%b", beat_no,
                         diff_out[DW-1:0], data_cur_out[DW-1:0], delay_clamped);
            end
        end
        if (hold_en && !valid_out) check("hold_in_bubble", diff_out, last_diff);
        last_diff = diff_out;
    end

    initial begin
        logic [DW-1:0] lane0;
        rst = 1'b1; flush = 1'b0; valid_in = 1'b0; delay_sel = 7'd5; mode = 2'b00; data_in = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_valid_out", LW'(valid_out), LW'(0));
        check("rst_diff_out", diff_out, '0);
        check("rst_data_cur_out", data_cur_out, '0);
        check("rst_delay_clamped", LW'(delay_clamped), LW'(0));

        // Ramp at D=5: beat 1 is cold, beat 2 appears three edges after acceptance.
        rst = 1'b0;
        ramp(1, 5, 2'b00, 0);
        check("lat_after_b1", LW'(valid_out), LW'(0));
        ramp(1, 5, 2'b00, 0);
        check("lat_after_b2", LW'(valid_out), LW'(0));
        ramp(0, 5, 2'b00, 0);
        check("lat_b1_cold_out", LW'(valid_out), LW'(0));
        ramp(0, 5, 2'b00, 0);
        check("lat_b2_out", LW'(valid_out), LW'(1));
        lane0 = diff_out[DW-1:0];
        check("ramp_diff_m5", LW'(lane0), LW'(20'hFFFFB));
        for (int i = 0; i < 10; i++) ramp(1, 5, 2'b00, 0);

        // Max delay from a fresh flush, then clamped low and high requests.
        ramp(1, 64, 2'b00, 1);
        for (int i = 0; i < 7; i++) ramp(1, 64, 2'b00, 0);
        for (int i = 0; i < 3; i++) ramp(1, 0, 2'b00, 0);
        for (int i = 0; i < 3; i++) ramp(1, 100, 2'b00, 0);

        // Alternating gaps at D=17; outputs must hold through bubbles.
        hold_en = 1'b1;
        for (int i = 0; i < 14; i++) ramp((i % 2) == 0, 17, 2'b00, 0);
        for (int i = 0; i < 3; i++) ramp(0, 17, 2'b00, 0);
        hold_en = 1'b0;

        // Saturation / wrap: max positive delayed minus max negative current.
        drive(1, 16, 2'b00, 0, {LANES{20'h7FFFF}});
        drive(1, 16, 2'b00, 0, {LANES{20'h80000}});
        for (int i = 0; i < 3; i++) ramp(0, 16, 2'b00, 0);
        lane0 = diff_out[DW-1:0];
        check("sat_lane0", LW'(lane0), LW'(SAT_EXP));

        // Output modes at D=3.
        for (int m = 1; m < 4; m++)
            for (int i = 0; i < 4; i++) ramp(1, 3, 2'(m), 0);

        // Flush mid-stream at D=5.
        for (int i = 0; i < 3; i++) ramp(1, 5, 2'b00, 0);
        ramp(1, 5, 2'b00, 1);
        for (int i = 0; i < 4; i++) ramp(1, 5, 2'b00, 0);

        // One-cycle reset mid-stream; the word offered with it is discarded.
        for (int i = 0; i < 2; i++) ramp(1, 5, 2'b00, 0);
        rst = 1'b1;
        valid_in = 1'b1;
        data_in = {LANES{20'h12345}};
        @(posedge clk); #1;
        check("midrst_valid_out", LW'(valid_out), LW'(0));
        check("midrst_diff_out", diff_out, '0);
        check("midrst_data_cur_out", data_cur_out, '0);
        check("midrst_delay_clamped", LW'(delay_clamped), LW'(0));
        exp_q.delete();
        stream.delete();
        beats_since = 0;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) ramp(1, 5, 2'b00, 0);

        // Drain and confirm every expected beat appeared.
        for (int i = 0; i < 6; i++) ramp(0, 5, 2'b00, 0);
        check("sb_drained", LW'(exp_q.size()), LW'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
